// File: rtl/mux_stream_rr_if.sv
// Stream bundle for mux_stream_rr: N input channels, one registered output channel.
// MUX_STREAM_LOCK_EN adds in_last/out_last packet framing.
interface mux_stream_rr_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 8
);
  localparam int unsigned SELW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SELW-1:0]    select;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_src;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_STREAM_LOCK_EN
  logic [N-1:0]       in_last;
  logic               out_last;

  modport master (
    output in_data, in_valid, mode, select, out_ready, in_last,
    input  in_ready, out_data, out_src, out_valid, out_last
  );
  modport slave (
    input  in_data, in_valid, mode, select, out_ready, in_last,
    output in_ready, out_data, out_src, out_valid, out_last
  );
`else
  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );
  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
`endif
endinterface

// File: rtl/mux_stream_rr.sv
// N-to-1 registered stream mux with explicit-select or round-robin arbitration.
// Define MUX_STREAM_LOCK_EN to hold the grant on one channel until its in_last beat.
module mux_stream_rr #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 8
) (
  input logic            clk,
  input logic            reset_n,
  mux_stream_rr_if.slave bus
);
  localparam int unsigned SELW = $clog2(N);

  logic [WIDTH-1:0] chan_data [N];
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_src_q, out_src_d;
  logic [SELW-1:0]  arb_grant, grant;
  logic             arb_valid, grant_valid, rr_found;
  logic             pipe_ready, xfer, last_beat;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    assign chan_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
  end

  // Round-robin scans [rr_ptr..N-1] first, then wraps to [0..rr_ptr-1].
  always_comb begin
    arb_grant = '0;
    arb_valid = 1'b0;
    rr_found  = 1'b0;
    if (!bus.mode) begin
      if (32'(bus.select) < N) begin
        arb_grant = bus.select;
        arb_valid = bus.in_valid[bus.select];
      end
    end else begin
      for (int c = 0; c < int'(N); c++) begin
        if (!rr_found && c >= int'(rr_ptr_q) && bus.in_valid[c]) begin
          arb_grant = SELW'(c);
          rr_found  = 1'b1;
        end
      end
      for (int c = 0; c < int'(N); c++) begin
        if (!rr_found && bus.in_valid[c]) begin
          arb_grant = SELW'(c);
          rr_found  = 1'b1;
        end
      end
      arb_valid = rr_found;
    end
  end

`ifdef MUX_STREAM_LOCK_EN
  logic            lock_q, lock_d;
  logic [SELW-1:0] lock_ch_q, lock_ch_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  always_comb begin
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (xfer) begin
      lock_d    = !bus.in_last[grant];
      lock_ch_d = grant;
    end
  end

  always_comb begin
    if (lock_q) begin
      grant       = lock_ch_q;
      grant_valid = bus.in_valid[lock_ch_q];
    end else begin
      grant       = arb_grant;
      grant_valid = arb_valid;
    end
  end

  assign last_beat = bus.in_last[grant];

  logic out_last_q, out_last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_last_q <= 1'b0;
    end else begin
      out_last_q <= out_last_d;
    end
  end

  always_comb begin
    out_last_d = out_last_q;
    if (xfer) begin
      out_last_d = bus.in_last[grant];
    end
  end

  assign bus.out_last = out_last_q;
`else
  assign grant       = arb_grant;
  assign grant_valid = arb_valid;
  assign last_beat   = 1'b1;
`endif

  assign pipe_ready = !out_valid_q || bus.out_ready;
  assign xfer       = grant_valid && pipe_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = chan_data[grant];
      out_src_d   = grant;
      if (bus.mode && last_beat) begin
        rr_ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // in_ready is forced low during reset even though the output stage looks empty.
  always_comb begin
    bus.in_ready = '0;
    if (reset_n && xfer) begin
      bus.in_ready = N'(1) << grant;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_mux_stream_rr.sv
// Self-checking bench for mux_stream_rr: 8-channel instance against a reference model,
// plus a 5-channel instance for non-power-of-two boundaries.
module tb_mux_stream_rr;
  localparam int W  = 8;
  localparam int N8 = 8;
  localparam int N5 = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mux_stream_rr_if #(.WIDTH(W), .N(N8)) b8 ();
  mux_stream_rr_if #(.WIDTH(W), .N(N5)) b5 ();

  mux_stream_rr #(.WIDTH(W), .N(N8)) u8 (.clk(clk), .reset_n(reset_n), .bus(b8.slave));
  mux_stream_rr #(.WIDTH(W), .N(N5)) u5 (.clk(clk), .reset_n(reset_n), .bus(b5.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the 8-channel instance: what the output register should hold.
  bit         m_valid;
  logic [7:0] m_data;
  int         m_src;
  int         m_ptr;
  bit         e_gv;
  int         e_g;
  logic [7:0] e_ready;

  task automatic model_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_src   = 0;
    m_ptr   = 0;
  endtask

  task automatic predict();
    e_gv = 0;
    e_g  = 0;
    if (!b8.mode) begin
      if (int'(b8.select) < N8 && b8.in_valid[b8.select]) begin
        e_gv = 1;
        e_g  = int'(b8.select);
      end
    end else begin
      for (int k = 0; k < N8; k++) begin
        int c;
        c = (m_ptr + k) % N8;
        if (!e_gv && b8.in_valid[c]) begin
          e_gv = 1;
          e_g  = c;
        end
      end
    end
    e_ready = (reset_n && e_gv && (!m_valid || b8.out_ready)) ? (8'h01 << e_g) : 8'h00;
  endtask

  // One clock, advancing the model alongside; returns at the following falling edge.
  task automatic clock();
    predict();
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (e_gv && (!m_valid || b8.out_ready)) begin
      m_valid = 1;
      m_data  = b8.in_data[e_g*8 +: 8];
      m_src   = e_g;
      if (b8.mode) m_ptr = (e_g + 1) % N8;
    end else if (b8.out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N8; i++) b8.in_data[i*8 +: 8] = 8'h10 + 8'(i);
    for (int i = 0; i < N5; i++) b5.in_data[i*8 +: 8] = 8'h20 + 8'(i);
    b8.in_valid = 8'hFF; b8.mode = 1'b0; b8.select = 3'd0; b8.out_ready = 1'b1;
    b5.in_valid = 5'h00; b5.mode = 1'b0; b5.select = 3'd0; b5.out_ready = 1'b1;
`ifdef MUX_STREAM_LOCK_EN
    b8.in_last = 8'hFF;
    b5.in_last = 5'h1F;
`endif
    #2 reset_n = 1'b0;
    b5.in_valid = 5'h1F;
    @(negedge clk);
    n_cmp++;
    if (b8.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid got=%b exp=0", b8.out_valid);
    end
    n_cmp++;
    if (b8.out_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_out_data got=%h exp=00", b8.out_data);
    end
    n_cmp++;
    if (b8.in_ready !== 8'h00 || b5.in_ready !== 5'h00) begin
      n_bad++; $display("FAIL reset_in_ready got=%b/%b exp=0", b8.in_ready, b5.in_ready);
    end
    b5.in_valid = 5'h00;
    model_reset();
    reset_n = 1'b1;
    #1;
    n_cmp++;
    if (b8.in_ready !== 8'h01) begin
      n_bad++; $display("FAIL release_in_ready got=%b exp=00000001", b8.in_ready);
    end
    clock();
    n_cmp++;
    if (b8.out_valid !== 1'b1 || b8.out_data !== 8'h10 || b8.out_src !== 3'd0) begin
      n_bad++;
      $display("FAIL first_beat got v=%b d=%h s=%0d exp v=1 d=10 s=0",
               b8.out_valid, b8.out_data, b8.out_src);
    end
  endtask

  task automatic test_sweep();
    for (int s = 0; s < N8; s++) begin
      b8.select = 3'(s);
      #1;
      n_cmp++;
      if (b8.in_ready !== (8'h01 << s)) begin
        n_bad++; $display("FAIL sweep_in_ready s=%0d got=%b", s, b8.in_ready);
      end
      clock();
      n_cmp++;
      if (b8.out_data !== 8'h10 + 8'(s) || b8.out_src !== 3'(s) || b8.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL sweep_out s=%0d got d=%h src=%0d v=%b exp d=%h src=%0d v=1",
                 s, b8.out_data, b8.out_src, b8.out_valid, 8'h10 + 8'(s), s);
      end
    end
  endtask

  task automatic test_rr_fair();
    int exp_seq [8] = '{0, 2, 5, 7, 0, 2, 5, 7};
    b8.mode = 1'b1;
    b8.in_valid = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++;
      if (b8.in_ready !== (8'h01 << exp_seq[k])) begin
        n_bad++;
        $display("FAIL rr_in_ready k=%0d got=%b exp_ch=%0d", k, b8.in_ready, exp_seq[k]);
      end
      clock();
      n_cmp++;
      if (b8.out_src !== 3'(exp_seq[k])) begin
        n_bad++; $display("FAIL rr_out_src k=%0d got=%0d exp=%0d", k, b8.out_src, exp_seq[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    b8.mode = 1'b0; b8.select = 3'd3; b8.in_valid = 8'hFF; b8.out_ready = 1'b1;
    b8.in_data[3*8 +: 8] = 8'hA5;
    #1 clock();
    n_cmp++;
    if (b8.out_data !== 8'hA5 || b8.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_load got d=%h v=%b exp d=a5 v=1", b8.out_data, b8.out_valid);
    end
    b8.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      b8.in_data[3*8 +: 8] = 8'h60 + 8'(k);
      #1;
      n_cmp++;
      if (b8.in_ready !== 8'h00) begin
        n_bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, b8.in_ready);
      end
      clock();
      n_cmp++;
      if (b8.out_data !== 8'hA5 || b8.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold k=%0d got d=%h v=%b exp d=a5 v=1", k, b8.out_data, b8.out_valid);
      end
    end
    b8.in_data[3*8 +: 8] = 8'h5A;
    b8.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (b8.in_ready !== 8'h08) begin
      n_bad++; $display("FAIL bp_release_ready got=%b exp=00001000", b8.in_ready);
    end
    clock();
    n_cmp++;
    if (b8.out_data !== 8'h5A || b8.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_no_bubble got d=%h v=%b exp d=5a v=1", b8.out_data, b8.out_valid);
    end
  endtask

  task automatic test_boundary_n5();
    b5.mode = 1'b0; b5.select = 3'd6; b5.in_valid = 5'h1F; b5.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (b5.in_ready !== 5'h00) begin
      n_bad++; $display("FAIL n5_sel_oob_ready got=%b exp=00000", b5.in_ready);
    end
    clock();
    n_cmp++;
    if (b5.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL n5_sel_oob_valid got=%b exp=0", b5.out_valid);
    end
    b5.mode = 1'b1; b5.in_valid = 5'h10;
    #1;
    n_cmp++;
    if (b5.in_ready !== 5'h10) begin
      n_bad++; $display("FAIL n5_rr_ch4_ready got=%b exp=10000", b5.in_ready);
    end
    clock();
    n_cmp++;
    if (b5.out_src !== 3'd4 || b5.out_data !== 8'h24 || b5.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL n5_rr_ch4_out got s=%0d d=%h v=%b exp s=4 d=24 v=1",
               b5.out_src, b5.out_data, b5.out_valid);
    end
    b5.in_valid = 5'h1F;
    #1;
    n_cmp++;
    if (b5.in_ready !== 5'h01) begin
      n_bad++; $display("FAIL n5_rr_wrap_ready got=%b exp=00001", b5.in_ready);
    end
    clock();
    n_cmp++;
    if (b5.out_src !== 3'd0) begin
      n_bad++; $display("FAIL n5_rr_wrap_src got=%0d exp=0", b5.out_src);
    end
    b5.in_valid = 5'h00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      b8.in_data   = {$urandom, $urandom};
      b8.mode      = 1'($urandom_range(0, 1));
      b8.select    = 3'($urandom_range(0, 7));
      b8.in_valid  = 8'($urandom);
      b8.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      n_cmp++;
      if (b8.in_ready !== e_ready) begin
        n_bad++; $display("FAIL rand_in_ready i=%0d got=%b exp=%b", i, b8.in_ready, e_ready);
      end
      clock();
      n_cmp++;
      if (b8.out_valid !== 1'(m_valid) || b8.out_data !== m_data || b8.out_src !== 3'(m_src)) begin
        n_bad++;
        $display("FAIL rand_out i=%0d got v=%b d=%h s=%0d exp v=%b d=%h s=%0d", i,
                 b8.out_valid, b8.out_data, b8.out_src, m_valid, m_data, m_src);
      end
    end
  endtask

  task automatic test_mid_reset();
    b8.mode = 1'b0; b8.select = 3'd2; b8.in_valid = 8'hFF; b8.out_ready = 1'b0;
    #1 clock();
    n_cmp++;
    if (b8.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL midrst_loaded got=%b exp=1", b8.out_valid);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (b8.out_valid !== 1'b0 || b8.out_data !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst_async got v=%b d=%h exp v=0 d=00", b8.out_valid, b8.out_data);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    b8.out_ready = 1'b1;
    b8.in_valid = 8'h00;
    #1 clock();
  endtask

`ifdef MUX_STREAM_LOCK_EN
  task automatic test_lock();
    int         exp_src [4] = '{1, 1, 1, 2};
    logic [7:0] exp_dat [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hD0};
    logic       exp_lst [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    b8.mode = 1'b0; b8.select = 3'd1; b8.out_ready = 1'b1;
    b8.in_valid = 8'b0000_0110;
    b8.in_last  = 8'b1111_1101;
    b8.in_data[2*8 +: 8] = 8'hD0;
    for (int k = 0; k < 4; k++) begin
      b8.in_data[1*8 +: 8] = exp_dat[k];
      if (k == 1) b8.select = 3'd2;
      if (k == 2) b8.in_last[1] = 1'b1;
      if (k == 3) b8.in_valid = 8'b0000_0100;
      #1;
      n_cmp++;
      if (b8.in_ready !== (8'h01 << exp_src[k])) begin
        n_bad++; $display("FAIL lock_ready k=%0d got=%b exp_ch=%0d", k, b8.in_ready, exp_src[k]);
      end
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (b8.out_src !== 3'(exp_src[k]) || b8.out_data !== exp_dat[k]
          || b8.out_last !== exp_lst[k]) begin
        n_bad++;
        $display("FAIL lock_out k=%0d got s=%0d d=%h l=%b exp s=%0d d=%h l=%b", k,
                 b8.out_src, b8.out_data, b8.out_last, exp_src[k], exp_dat[k], exp_lst[k]);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_sweep();
    test_rr_fair();
    test_backpressure();
    test_boundary_n5();
    test_random();
    test_mid_reset();
`ifdef MUX_STREAM_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mux_stream_rr.md
Name: mux_stream_rr

Overview:
- Parametrised N-to-1 W-bit stream multiplexer with a registered output stage and valid/ready handshaking on every input and on the output.
- Generalises the combinational 8:1 select mux to arbitrary width and input count.
- Adds two selection modes: explicit select, and round-robin arbitration.
- Sits between multiple producers (e.g. register-file read ports, bus masters) and a single consumer in the datapath.

Parameters:
- WIDTH, 64, data bits per channel
- N, 8, number of input channels (2..32, need not be a power of 2)
- SELW, $clog2(N), width of select/source fields (derived; do not override)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready; combinational from state and inputs
- mode  input  1  0 = explicit select, 1 = round-robin
- select  input  SELW  channel index used when mode=0
- out_data  output  WIDTH  registered selected data
- out_src  output  SELW  registered index of the channel that supplied out_data
- out_valid  output  1  registered output valid
- out_ready  input  1  consumer ready

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - in_ready is all 0 while reset_n=0.
- Pipeline ready: pipe_ready = !out_valid || out_ready. Throughput is 1 beat/cycle; latency is 1 cycle from input transfer to out_valid.
- Grant, mode=0:
  - grant=select when select<N and in_valid[select]=1.
  - No grant when select>=N or the selected channel is not valid.
- Grant, mode=1:
  - grant = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, … mod N.
  - No grant if in_valid==0.
- in_ready[i] = pipe_ready && grant_valid && (grant==i). At most one bit of in_ready is set in any cycle.
- Input transfer (grant_valid && pipe_ready):
  - out_data <= in_data[grant]; out_src <= grant; out_valid <= 1.
  - In mode=1, rr_ptr <= (grant==N-1) ? 0 : grant+1.
  - In mode=0, rr_ptr is unchanged.
- No input transfer but out_ready=1: out_valid <= 0. out_data and out_src hold their last value.
- Output stall: out_valid=1 && out_ready=0 holds out_data, out_src and out_valid, and forces in_ready=0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant_valid=1): both happen in the same cycle; out_valid stays 1 with no bubble.
- Mode or select change: takes effect combinationally in the same cycle. It never disturbs a beat already held in the output register.
- Wrap: with N not a power of 2, rr_ptr never holds a value >= N.
- Reset mid-operation: a beat held in the output register is discarded and out_valid drops asynchronously.

Optional Feature:
- Macro: MUX_STREAM_LOCK_EN
- When defined:
  - Adds ports in_last (input, N) and out_last (output, 1, registered, reset 0).
  - Once a beat with in_valid[g]=1 and in_last[g]=0 transfers from channel g, the grant is locked to g, ignoring mode, select and rr_ptr.
  - The lock releases after the beat with in_last[g]=1 transfers.
  - rr_ptr advances only on that final beat.
  - Lock state resets to unlocked.
- When undefined: no in_last/out_last ports, and arbitration is re-evaluated every beat.

Test Plan:
- Reset/idle: reset_n=0 with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0. After release with out_ready=1, the first beat appears one cycle later.
- Explicit sweep:
  - N=8, WIDTH=8, in_data channel i = 8'h10+i, mode=0, all valid, out_ready=1.
  - select stepped 0..7 each cycle -> out_data 8'h10..8'h17 one cycle later; out_src matches select.
- Round-robin fairness:
  - mode=1, in_valid=8'b1010_0101 held, out_ready=1.
  - -> out_src sequence 0,2,5,7,0,2,…, with each in_ready pulse on the matching channel.
- Backpressure:
  - out_ready=0 for 3 cycles with channel 3 valid (data 8'hA5).
  - -> out_data stays 8'hA5, in_ready=0 throughout.
  - Raising out_ready gives a drain and a new fill in the same cycle with no bubble.
- Boundaries:
  - N=5, mode=0, select=6 -> no grant and in_ready=0.
  - mode=1 with only channel 4 valid -> grant 4; rr_ptr wraps to 0.
  - reset_n pulsed low while out_valid=1 -> out_valid=0 immediately.
- Lock (MUX_STREAM_LOCK_EN):
  - Channel 1 sends a 3-beat packet (in_last on beat 3) while channel 2 is valid.
  - -> out_src = 1,1,1, then 2; out_last=1 only on the third beat.
